video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen_pkg.sv | 40 ++++
 rtl/video_timing_gen_if.sv | 21 ++
 rtl/video_timing_gen_axis_cnt.sv | 47 ++++
 rtl/video_timing_gen.sv | 103 ++++++++++
 tb/tb_video_timing_gen.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_gen_pkg.sv
// Standard raster timing sets shared by every video_timing_gen instantiation.
// An instance picks one set and passes its fields as parameters.
package video_timing_pkg;

    typedef struct packed {
        int   h_sync;
        int   h_bp;
        int   h_act;
        int   h_fp;
        int   v_sync;
        int   v_bp;
        int   v_act;
        int   v_fp;
        logic hs_pol;
        logic vs_pol;
    } timing_t;

    localparam timing_t TIMING_720P60 = '{
        h_sync: 40, h_bp: 220, h_act: 1280, h_fp: 110,
        v_sync: 5,  v_bp: 20,  v_act: 720,  v_fp: 5,
        hs_pol: 1'b1, vs_pol: 1'b1
    };

    localparam timing_t TIMING_1080P60 = '{
        h_sync: 44, h_bp: 148, h_act: 1920, h_fp: 88,
        v_sync: 5,  v_bp: 36,  v_act: 1080, v_fp: 4,
        hs_pol: 1'b1, vs_pol: 1'b1
    };

    localparam timing_t TIMING_640X480P60 = '{
        h_sync: 96, h_bp: 48, h_act: 640, h_fp: 16,
        v_sync: 2,  v_bp: 33, v_act: 480, v_fp: 10,
        hs_pol: 1'b0, vs_pol: 1'b0
    };

    function automatic int axis_total(int sync, int bp, int act, int fp);
        return sync + bp + act + fp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster output bundle: syncs, data enable, active-area coordinates and frame tick.
// The timing generator drives the master side; the pixel-colour stage takes the slave side.
interface video_timing_gen_if #(
    parameter int X_BITS = 12,
    parameter int Y_BITS = 12
);
    logic              hs_out;
    logic              vs_out;
    logic              de_out;
    logic [X_BITS-1:0] act_x;
    logic [Y_BITS-1:0] act_y;
    logic              frame_start;

    modport master (
        output hs_out, vs_out, de_out, act_x, act_y, frame_start
    );

    modport slave (
        input hs_out, vs_out, de_out, act_x, act_y, frame_start
    );
endinterface

// File: rtl/video_timing_gen_axis_cnt.sv
// One raster axis: a wrapping position counter plus combinational region decode.
// Region order along the axis is sync, back porch, active, front porch.
module timing_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int SYNC  = 40,
    parameter int BP    = 220,
    parameter int ACT   = 1280,
    parameter int FP    = 110,
    parameter int WIDTH = 12
) (
    input  logic             pix_clk,
    input  logic             rstn,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_sync_active,
    output logic             o_act_active,
    output logic [WIDTH-1:0] o_act_coord
);
    localparam int TOTAL = axis_total(SYNC, BP, ACT, FP);
    localparam int START = SYNC + BP;

    localparam logic [WIDTH-1:0] LAST     = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] SYNC_END = WIDTH'(SYNC);
    localparam logic [WIDTH-1:0] ACT_BEG  = WIDTH'(START);
    // One extra bit: the active end equals TOTAL when there is no front porch.
    localparam logic [WIDTH:0]   ACT_END  = (WIDTH+1)'(START + ACT);

    logic [WIDTH-1:0] r_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt         = r_cnt;
    assign o_wrap        = (r_cnt == LAST);
    assign o_sync_active = (r_cnt < SYNC_END);
    assign o_act_active  = (r_cnt >= ACT_BEG) && ({1'b0, r_cnt} < ACT_END);
    assign o_act_coord   = o_act_active ? (r_cnt - ACT_BEG) : '0;

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: hs/vs/de, active coordinates and a frame tick,
// all registered one cycle after the counter state they decode.
module video_timing_gen
    import video_timing_pkg::*;
#(
    // X_BITS must hold H_TOTAL-1 and Y_BITS must hold V_TOTAL-1.
    parameter int   X_BITS = 12,
    parameter int   Y_BITS = 12,
    parameter int   H_SYNC = TIMING_720P60.h_sync,
    parameter int   H_BP   = TIMING_720P60.h_bp,
    parameter int   H_ACT  = TIMING_720P60.h_act,
    parameter int   H_FP   = TIMING_720P60.h_fp,
    parameter int   V_SYNC = TIMING_720P60.v_sync,
    parameter int   V_BP   = TIMING_720P60.v_bp,
    parameter int   V_ACT  = TIMING_720P60.v_act,
    parameter int   V_FP   = TIMING_720P60.v_fp,
    parameter logic HS_POL = TIMING_720P60.hs_pol,
    parameter logic VS_POL = TIMING_720P60.vs_pol
) (
    input  logic                pix_clk,
    input  logic                rstn,
    video_timing_gen_if.master  o_vid
);
    logic [X_BITS-1:0] w_h_cnt;
    logic [X_BITS-1:0] w_h_coord;
    logic              w_h_wrap;
    logic              w_h_sync;
    logic              w_h_act;

    logic [Y_BITS-1:0] w_v_cnt;
    logic [Y_BITS-1:0] w_v_coord;
    logic              w_unused_v_wrap;
    logic              w_v_sync;
    logic              w_v_act;

    timing_axis_cnt #(
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .ACT  (H_ACT),
        .FP   (H_FP),
        .WIDTH(X_BITS)
    ) u_h_axis (
        .pix_clk      (pix_clk),
        .rstn         (rstn),
        .i_en         (1'b1),
        .o_cnt        (w_h_cnt),
        .o_wrap       (w_h_wrap),
        .o_sync_active(w_h_sync),
        .o_act_active (w_h_act),
        .o_act_coord  (w_h_coord)
    );

    // Advancing only on the last pixel of a line keeps vsync edges on line boundaries.
    timing_axis_cnt #(
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .ACT  (V_ACT),
        .FP   (V_FP),
        .WIDTH(Y_BITS)
    ) u_v_axis (
        .pix_clk      (pix_clk),
        .rstn         (rstn),
        .i_en         (w_h_wrap),
        .o_cnt        (w_v_cnt),
        .o_wrap       (w_unused_v_wrap),
        .o_sync_active(w_v_sync),
        .o_act_active (w_v_act),
        .o_act_coord  (w_v_coord)
    );

    logic              r_hs;
    logic              r_vs;
    logic              r_de;
    logic [X_BITS-1:0] r_act_x;
    logic [Y_BITS-1:0] r_act_y;
    logic              r_frame_start;

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_de          <= 1'b0;
            r_act_x       <= '0;
            r_act_y       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hs          <= w_h_sync ? HS_POL : ~HS_POL;
            r_vs          <= w_v_sync ? VS_POL : ~VS_POL;
            r_de          <= w_h_act && w_v_act;
            r_act_x       <= w_h_coord;
            r_act_y       <= w_v_coord;
            r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
        end
    end

    assign o_vid.hs_out      = r_hs;
    assign o_vid.vs_out      = r_vs;
    assign o_vid.de_out      = r_de;
    assign o_vid.act_x       = r_act_x;
    assign o_vid.act_y       = r_act_y;
    assign o_vid.frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two small raster builds checked cycle by cycle against an
// arithmetic raster model, plus frame-level measurements and randomized mid-frame resets.
`timescale 1ns/1ps
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam timing_t CFG_A = '{
        h_sync: 2, h_bp: 2, h_act: 4, h_fp: 2,
        v_sync: 1, v_bp: 1, v_act: 3, v_fp: 1,
        hs_pol: 1'b0, vs_pol: 1'b0
    };
    localparam timing_t CFG_B = '{
        h_sync: 4, h_bp: 6, h_act: 16, h_fp: 3,
        v_sync: 2, v_bp: 3, v_act: 5,  v_fp: 2,
        hs_pol: 1'b1, vs_pol: 1'b1
    };
    localparam int FR_A = 60;   // 10 x 6
    localparam int HT_B = 29;
    localparam int FR_B = 348;  // 29 x 12

    // Packed view: {frame_start, de, vs, hs, act_y[11:0], act_x[11:0]}
    localparam logic [27:0] RST_A = 28'h300_0000;
    localparam logic [27:0] RST_B = 28'h000_0000;

    logic pix_clk = 1'b0;
    logic rstn    = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;

    always #5 pix_clk = ~pix_clk;

    video_timing_gen_if #(.X_BITS(4), .Y_BITS(3)) vid_a ();
    video_timing_gen_if #(.X_BITS(5), .Y_BITS(4)) vid_b ();

    video_timing_gen #(
        .X_BITS(4), .Y_BITS(3),
        .H_SYNC(CFG_A.h_sync), .H_BP(CFG_A.h_bp), .H_ACT(CFG_A.h_act), .H_FP(CFG_A.h_fp),
        .V_SYNC(CFG_A.v_sync), .V_BP(CFG_A.v_bp), .V_ACT(CFG_A.v_act), .V_FP(CFG_A.v_fp),
        .HS_POL(CFG_A.hs_pol), .VS_POL(CFG_A.vs_pol)
    ) u_dut_a (
        .pix_clk(pix_clk),
        .rstn   (rstn),
        .o_vid  (vid_a)
    );

    video_timing_gen #(
        .X_BITS(5), .Y_BITS(4),
        .H_SYNC(CFG_B.h_sync), .H_BP(CFG_B.h_bp), .H_ACT(CFG_B.h_act), .H_FP(CFG_B.h_fp),
        .V_SYNC(CFG_B.v_sync), .V_BP(CFG_B.v_bp), .V_ACT(CFG_B.v_act), .V_FP(CFG_B.v_fp),
        .HS_POL(CFG_B.hs_pol), .VS_POL(CFG_B.vs_pol)
    ) u_dut_b (
        .pix_clk(pix_clk),
        .rstn   (rstn),
        .o_vid  (vid_b)
    );

    // Expected outputs after the k-th rising edge since reset release: that edge
    // publishes the decode of raster position k (mod frame length).
    function automatic logic [27:0] model(timing_t c, int k);
        int   ht, vt, p, h, v, hs0, vs0, x, y;
        logic ha, va, hs, vs;
        ht  = c.h_sync + c.h_bp + c.h_act + c.h_fp;
        vt  = c.v_sync + c.v_bp + c.v_act + c.v_fp;
        p   = k % (ht * vt);
        h   = p % ht;
        v   = p / ht;
        hs0 = c.h_sync + c.h_bp;
        vs0 = c.v_sync + c.v_bp;
        ha  = (h >= hs0) && (h < hs0 + c.h_act);
        va  = (v >= vs0) && (v < vs0 + c.v_act);
        hs  = (h < c.h_sync) ? c.hs_pol : ~c.hs_pol;
        vs  = (v < c.v_sync) ? c.vs_pol : ~c.vs_pol;
        x   = ha ? h - hs0 : 0;
        y   = va ? v - vs0 : 0;
        return {(p == 0), (ha && va), vs, hs, 12'(y), 12'(x)};
    endfunction

    function automatic logic [27:0] obs_a();
        return {vid_a.frame_start, vid_a.de_out, vid_a.vs_out, vid_a.hs_out,
                12'(vid_a.act_y), 12'(vid_a.act_x)};
    endfunction

    function automatic logic [27:0] obs_b();
        return {vid_b.frame_start, vid_b.de_out, vid_b.vs_out, vid_b.hs_out,
                12'(vid_b.act_y), 12'(vid_b.act_x)};
    endfunction

    task automatic step(output int k);
        @(negedge pix_clk);
        k = cyc;
        cyc++;
    endtask

    task automatic release_reset();
        @(negedge pix_clk);
        rstn = 1'b1;
        cyc  = 0;
    endtask

    task automatic test_reset();
        int k;
        rstn = 1'b0;
        repeat (3) @(negedge pix_clk);
        checks++;
        if (obs_a() !== RST_A) begin
            errors++; $display("FAIL reset_a got=%h exp=%h", obs_a(), RST_A);
        end
        checks++;
        if (obs_b() !== RST_B) begin
            errors++; $display("FAIL reset_b got=%h exp=%h", obs_b(), RST_B);
        end
        release_reset();
        step(k);
        checks++;
        if (obs_a() !== model(CFG_A, k)) begin
            errors++; $display("FAIL first_edge_a got=%h exp=%h", obs_a(), model(CFG_A, k));
        end
        checks++;
        if ({vid_a.frame_start, vid_a.hs_out, vid_a.vs_out} !== 3'b100) begin
            errors++; $display("FAIL first_edge_a_sync got fs/hs/vs=%b%b%b exp=100",
                               vid_a.frame_start, vid_a.hs_out, vid_a.vs_out);
        end
        checks++;
        if (obs_b() !== model(CFG_B, k)) begin
            errors++; $display("FAIL first_edge_b got=%h exp=%h", obs_b(), model(CFG_B, k));
        end
        checks++;
        if ({vid_b.frame_start, vid_b.hs_out, vid_b.vs_out} !== 3'b111) begin
            errors++; $display("FAIL first_edge_b_sync got fs/hs/vs=%b%b%b exp=111",
                               vid_b.frame_start, vid_b.hs_out, vid_b.vs_out);
        end
    endtask

    task automatic test_small_exhaustive();
        int k;
        for (int i = 0; i < 2 * FR_A + 7; i++) begin
            step(k);
            checks++;
            if (obs_a() !== model(CFG_A, k)) begin
                errors++; $display("FAIL small_exh k=%0d got=%h exp=%h", k, obs_a(), model(CFG_A, k));
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int last_fs = -1;
        int n_fs    = 0;
        for (int i = 0; i < 5 * FR_A; i++) begin
            step(k);
            checks++;
            if (obs_a() !== model(CFG_A, k)) begin
                errors++; $display("FAIL b2b_model k=%0d got=%h exp=%h", k, obs_a(), model(CFG_A, k));
            end
            if (vid_a.frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (k - last_fs != FR_A) begin
                        errors++; $display("FAIL fs_gap_a got=%0d exp=%0d", k - last_fs, FR_A);
                    end
                end
                last_fs = k;
                n_fs++;
            end
        end
        checks++;
        if (n_fs != 5) begin
            errors++; $display("FAIL fs_count_a got=%0d exp=5", n_fs);
        end
    endtask

    task automatic test_wide_frame();
        int k;
        int f0 = -1, hs_rise = -1, hs_len = 0, vs_len = 0, de_len = 0, bursts = 0;
        bit done = 1'b0;
        bit p_hs, p_vs, p_de;
        p_hs = vid_b.hs_out;
        p_vs = vid_b.vs_out;
        p_de = vid_b.de_out;
        for (int i = 0; i < 3 * FR_B && !done; i++) begin
            step(k);
            checks++;
            if (obs_b() !== model(CFG_B, k)) begin
                errors++; $display("FAIL wide_model k=%0d got=%h exp=%h", k, obs_b(), model(CFG_B, k));
            end
            if (vid_b.frame_start === 1'b1) begin
                if (f0 >= 0) begin
                    checks++;
                    if (k - f0 != FR_B) begin
                        errors++; $display("FAIL fs_gap_b got=%0d exp=%0d", k - f0, FR_B);
                    end
                    checks++;
                    if (bursts != 5) begin
                        errors++; $display("FAIL de_bursts got=%0d exp=5", bursts);
                    end
                    done = 1'b1;
                end else begin
                    f0 = k;
                end
            end
            if (f0 >= 0 && !done) begin
                if (vid_b.hs_out && !p_hs) begin
                    if (hs_rise >= 0) begin
                        checks++;
                        if (k - hs_rise != HT_B) begin
                            errors++; $display("FAIL hs_period got=%0d exp=%0d", k - hs_rise, HT_B);
                        end
                    end
                    hs_rise = k;
                    hs_len  = 0;
                end
                if (vid_b.hs_out) hs_len++;
                if (!vid_b.hs_out && p_hs) begin
                    checks++;
                    if (hs_len != 4) begin
                        errors++; $display("FAIL hs_width got=%0d exp=4", hs_len);
                    end
                end
                if (vid_b.vs_out && !p_vs) begin
                    checks++;
                    if (!(vid_b.hs_out && !p_hs)) begin
                        errors++; $display("FAIL vs_line_align got hs=%b prev_hs=%b exp=1/0", vid_b.hs_out, p_hs);
                    end
                    vs_len = 0;
                end
                if (vid_b.vs_out) vs_len++;
                if (!vid_b.vs_out && p_vs) begin
                    checks++;
                    if (vs_len != 2 * HT_B) begin
                        errors++; $display("FAIL vs_width got=%0d exp=%0d", vs_len, 2 * HT_B);
                    end
                end
                if (vid_b.de_out && !p_de) begin
                    bursts++;
                    de_len = 0;
                    checks++;
                    if (k - hs_rise != 10) begin
                        errors++; $display("FAIL de_offset got=%0d exp=10", k - hs_rise);
                    end
                    if (bursts == 1) begin
                        checks++;
                        if ((k - f0) / HT_B != 5) begin
                            errors++; $display("FAIL first_de_line got=%0d exp=5", (k - f0) / HT_B);
                        end
                    end
                end
                if (vid_b.de_out) begin
                    de_len++;
                    checks++;
                    if (int'(vid_b.act_x) != de_len - 1 || int'(vid_b.act_y) != bursts - 1) begin
                        errors++; $display("FAIL act_sweep got x=%0d y=%0d exp x=%0d y=%0d",
                                           vid_b.act_x, vid_b.act_y, de_len - 1, bursts - 1);
                    end
                end
                if (!vid_b.de_out && p_de) begin
                    checks++;
                    if (de_len != 16 || vid_b.act_x !== 5'd0) begin
                        errors++; $display("FAIL de_burst got len=%0d x=%0d exp len=16 x=0", de_len, vid_b.act_x);
                    end
                end
            end
            p_hs = vid_b.hs_out;
            p_vs = vid_b.vs_out;
            p_de = vid_b.de_out;
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL wide_frame_timeout got done=0 exp done=1");
        end
    endtask

    task automatic test_mid_reset();
        int k, tx, ty;
        bit hit;
        for (int r = 0; r < 3; r++) begin
            tx  = $urandom_range(0, 15);
            ty  = $urandom_range(0, 4);
            hit = 1'b0;
            for (int i = 0; i < 2 * FR_B && !hit; i++) begin
                step(k);
                checks++;
                if (obs_b() !== model(CFG_B, k)) begin
                    errors++; $display("FAIL pre_reset_b k=%0d got=%h exp=%h", k, obs_b(), model(CFG_B, k));
                end
                if (vid_b.de_out === 1'b1 && int'(vid_b.act_x) == tx && int'(vid_b.act_y) == ty) hit = 1'b1;
            end
            checks++;
            if (!hit) begin
                errors++; $display("FAIL reset_target_timeout got none exp x=%0d y=%0d", tx, ty);
            end
            #2 rstn = 1'b0;
            #1;
            checks++;
            if (obs_a() !== RST_A) begin
                errors++; $display("FAIL async_reset_a got=%h exp=%h", obs_a(), RST_A);
            end
            checks++;
            if (obs_b() !== RST_B) begin
                errors++; $display("FAIL async_reset_b got=%h exp=%h", obs_b(), RST_B);
            end
            repeat ($urandom_range(1, 4)) @(negedge pix_clk);
            checks++;
            if (obs_b() !== RST_B) begin
                errors++; $display("FAIL held_reset_b got=%h exp=%h", obs_b(), RST_B);
            end
            release_reset();
            for (int i = 0; i < FR_B + 5; i++) begin
                step(k);
                checks++;
                if (obs_a() !== model(CFG_A, k)) begin
                    errors++; $display("FAIL post_reset_a k=%0d got=%h exp=%h", k, obs_a(), model(CFG_A, k));
                end
                checks++;
                if (obs_b() !== model(CFG_B, k)) begin
                    errors++; $display("FAIL post_reset_b k=%0d got=%h exp=%h", k, obs_b(), model(CFG_B, k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_small_exhaustive();
        test_back_to_back();
        test_wide_frame();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
